// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator: sums num_channels passes of row_len Psum words per row slot.
// Define PSUM_ACC_SAT_EN to saturate every sum at 2^ACC_WIDTH-1 instead of wrapping.
module psum_accumulator #(
  parameter int unsigned DATA_WIDTH     = 10,
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned ROW_ADDR_WIDTH = 4,
  parameter int unsigned ROW_DEPTH      = 11,
  parameter int unsigned CH_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [ROW_ADDR_WIDTH-1:0] row_len_in,
  input  logic [CH_WIDTH-1:0]       num_channels_in,
  input  logic [DATA_WIDTH-1:0]     Psum,
  input  logic                      valid_Psum,
  output logic                      ren_buf_Psum,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    r_state;
  logic [ROW_ADDR_WIDTH-1:0] r_row_len;
  logic [ROW_ADDR_WIDTH-1:0] r_idx;
  logic [CH_WIDTH-1:0]       r_num_ch;
  logic [CH_WIDTH-1:0]       r_pass;
  logic                      r_drain;
  logic [ACC_WIDTH-1:0]      r_acc [ROW_DEPTH];
  logic [ACC_WIDTH-1:0]      r_out_data;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_last_pass;
  logic                      w_last_idx;
  logic                      w_accept;
  logic                      w_out_free;
  logic                      w_pop;
  logic [ACC_WIDTH-1:0]      w_psum_ext;
  logic [ACC_WIDTH-1:0]      w_acc_rd;
  logic [ACC_WIDTH-1:0]      w_sum;
  logic [ACC_WIDTH-1:0]      w_new;

  assign w_last_pass = (r_pass == r_num_ch - CH_WIDTH'(1));
  assign w_last_idx  = (r_idx == r_row_len - ROW_ADDR_WIDTH'(1));
  assign w_accept    = r_out_valid & out_ready;
  assign w_out_free  = ~r_out_valid | out_ready;
  // Final-pass words only pop when the output register can take the result this cycle
  assign w_pop       = ~rst & (r_state == ACCUM) & ~r_drain & valid_Psum &
                       (~w_last_pass | w_out_free);

  assign w_psum_ext  = ACC_WIDTH'(Psum);
  assign w_acc_rd    = r_acc[r_idx];

`ifdef PSUM_ACC_SAT_EN
  logic [ACC_WIDTH:0] w_sum_full;
  assign w_sum_full = {1'b0, w_acc_rd} + {1'b0, w_psum_ext};
  assign w_sum      = w_sum_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_full[ACC_WIDTH-1:0];
`else
  assign w_sum      = w_acc_rd + w_psum_ext;
`endif

  // Pass 0 starts a fresh row slot, so stale acc contents are never read
  assign w_new = (r_pass == '0) ? w_psum_ext : w_sum;

  // Row accumulator memory, no reset needed
  always_ff @(posedge clk) begin
    if (w_pop && !w_last_pass) begin
      r_acc[r_idx] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row_len   <= '0;
      r_idx       <= '0;
      r_num_ch    <= '0;
      r_pass      <= '0;
      r_drain     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_pop && w_last_pass) begin
        r_out_data  <= w_new;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (Start && (row_len_in != '0) && (num_channels_in != '0)) begin
            r_row_len <= (32'(row_len_in) > ROW_DEPTH) ? ROW_ADDR_WIDTH'(ROW_DEPTH) : row_len_in;
            r_num_ch  <= num_channels_in;
            r_idx     <= '0;
            r_pass    <= '0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_pop) begin
            if (w_last_idx) begin
              r_idx <= '0;
              if (w_last_pass) begin
                r_drain <= 1'b1;
              end else begin
                r_pass <= r_pass + CH_WIDTH'(1);
              end
            end else begin
              r_idx <= r_idx + ROW_ADDR_WIDTH'(1);
            end
          end
          // Job ends once the final result has been accepted downstream
          if (r_drain && w_accept) begin
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ren_buf_Psum = w_pop;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized + directed bench for psum_accumulator; a 16-bit and a 10-bit accumulator run in lockstep.
module tb_psum_accumulator;
  localparam int unsigned DW = 10, AW = 16, AW10 = 10, RAW = 4, DEPTH = 11, CHW = 4;

  logic           clk = 1'b0;
  logic           rst, Start, valid_Psum, out_ready;
  logic [RAW-1:0] row_len_in;
  logic [CHW-1:0] num_channels_in;
  logic [DW-1:0]  Psum;
  logic           ren, ren10, ov, ov10, busy, busy10, done, done10;
  logic [AW-1:0]  od;
  logic [AW10-1:0] od10;

  always #5 clk = ~clk;

  psum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROW_ADDR_WIDTH(RAW),
                     .ROW_DEPTH(DEPTH), .CH_WIDTH(CHW)) u_dut (
    .clk(clk), .rst(rst), .Start(Start), .row_len_in(row_len_in),
    .num_channels_in(num_channels_in), .Psum(Psum), .valid_Psum(valid_Psum),
    .ren_buf_Psum(ren), .out_data(od), .out_valid(ov), .out_ready(out_ready),
    .busy(busy), .done(done));

  psum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW10), .ROW_ADDR_WIDTH(RAW),
                     .ROW_DEPTH(DEPTH), .CH_WIDTH(CHW)) u_dut10 (
    .clk(clk), .rst(rst), .Start(Start), .row_len_in(row_len_in),
    .num_channels_in(num_channels_in), .Psum(Psum), .valid_Psum(valid_Psum),
    .ren_buf_Psum(ren10), .out_data(od10), .out_valid(ov10), .out_ready(out_ready),
    .busy(busy10), .done(done10));

  typedef struct { int unsigned e16; int unsigned e10; } exp_t;

  exp_t           exp_q[$];
  logic [DW-1:0]  fifo[$];
  int             checks = 0;
  int             failures = 0;
  int             done_cnt = 0;
  logic           pop_flag = 1'b0;
  logic           gap = 1'b0;
  int             ready_mode = 0;
  int             stall_cnt = 0;
  logic           hold_prev = 1'b0;
  logic [AW-1:0]  hold_d;
  logic [AW10-1:0] hold_d10;
  int unsigned    wq[$], l16[$], l10[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference add at a given accumulator width
  function automatic int unsigned add_w(int unsigned a, int unsigned b, int unsigned w);
    longint unsigned s = longint'(a) + longint'(b);
    longint unsigned m = 64'd1 << w;
`ifdef PSUM_ACC_SAT_EN
    if (s >= m) return 32'(m - 1);
    return 32'(s);
`else
    return 32'(s % m);
`endif
  endfunction

  // Row slot i sums word i of every pass; outputs emerge in slot order
  function automatic void model_job(int rl, int nch, int unsigned w[$],
                                    int unsigned p16[$], int unsigned p10[$]);
    for (int i = 0; i < rl; i++) begin
      int unsigned s16 = w[i];
      int unsigned s10 = w[i];
      for (int c = 1; c < nch; c++) begin
        s16 = add_w(s16, w[c*rl + i], AW);
        s10 = add_w(s10, w[c*rl + i], AW10);
      end
      if (p16.size() > 0) begin
        chk("model_pin16", 64'(s16), 64'(p16[i]));
        chk("model_pin10", 64'(s10), 64'(p10[i]));
      end
      exp_q.push_back('{e16: s16, e10: s10});
    end
  endfunction

  // Compare process: protocol rules and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      chk("ren_in_reset", 64'(ren), 64'(0));
      pop_flag  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("ren_lockstep", 64'(ren10), 64'(ren));
      chk("valid_lockstep", 64'(ov10), 64'(ov));
      chk("busy_lockstep", 64'(busy10), 64'(busy));
      if (ren) begin
        chk("ren_needs_valid", 64'(valid_Psum), 64'(1));
        chk("ren_needs_busy", 64'(busy), 64'(1));
        chk("ren_while_out_full", 64'(ov & ~out_ready), 64'(0));
      end
      pop_flag = ren & valid_Psum;
      if (hold_prev) begin
        chk("hold_valid", 64'(ov), 64'(1));
        chk("hold_data", 64'(od), 64'(hold_d));
        chk("hold_data10", 64'(od10), 64'(hold_d10));
      end
      if (ov && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 64'(ov), 64'(0));
        end else begin
          chk("out_data", 64'(od), 64'(exp_q[0].e16));
          chk("out_data10", 64'(od10), 64'(exp_q[0].e10));
          void'(exp_q.pop_front());
        end
      end
      hold_prev = ov & ~out_ready;
      hold_d    = od;
      hold_d10  = od10;
      if (done) begin
        done_cnt++;
        chk("done_all_accepted", 64'(exp_q.size()), 64'(0));
        chk("done_fifo_empty", 64'(fifo.size()), 64'(0));
        chk("done10", 64'(done10), 64'(1));
        chk("busy_in_done", 64'(busy), 64'(0));
      end
    end
  end

  // One clock of stimulus: retire popped word, present FIFO head, pick out_ready
  task automatic step();
    @(posedge clk);
    #2;
    if (pop_flag) begin
      void'(fifo.pop_front());
      pop_flag = 1'b0;
    end
    if (fifo.size() > 0 && !gap) begin
      valid_Psum = 1'b1;
      Psum       = fifo[0];
    end else begin
      valid_Psum = 1'b0;
      Psum       = DW'($urandom);
    end
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (ov && stall_cnt < 4) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic run_job(int rl_in, int nch, int unsigned w[$], int unsigned p16[$],
                         int unsigned p10[$], int rmode, int gmode, int gap_start, bit noise);
    int rl   = (rl_in > int'(DEPTH)) ? int'(DEPTH) : rl_in;
    int base = done_cnt;
    model_job(rl, nch, w, p16, p10);
    for (int i = 0; i < rl * nch; i++) fifo.push_back(DW'(w[i]));
    ready_mode      = rmode;
    stall_cnt       = 0;
    row_len_in      = RAW'(rl_in);
    num_channels_in = CHW'(nch);
    Start           = 1'b1;
    step();
    Start = 1'b0;
    step();
    chk("busy_after_start", 64'(busy), 64'(1));
    for (int c = 0; c < 600 && done_cnt == base; c++) begin
      if (gmode == 1)      gap = (c >= gap_start && c < gap_start + 5);
      else if (gmode == 2) gap = ($urandom_range(0, 3) == 0);
      else                 gap = 1'b0;
      if (noise && c == 3) begin
        row_len_in      = RAW'($urandom);
        num_channels_in = CHW'($urandom);
        Start           = 1'b1;
      end
      step();
      Start = 1'b0;
    end
    gap = 1'b0;
    chk("job_done_count", 64'(done_cnt - base), 64'(1));
    step();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("idle_not_busy", 64'(busy), 64'(0));
    chk("idle_no_output", 64'(ov), 64'(0));
    fifo.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Start = 1'b0; valid_Psum = 1'b0; out_ready = 1'b1;
    row_len_in = '0; num_channels_in = '0; Psum = '0;
    repeat (3) step();
    chk("rst_out_valid", 64'(ov), 64'(0));
    chk("rst_out_data", 64'(od), 64'(0));
    chk("rst_out_data10", 64'(od10), 64'(0));
    chk("rst_ren", 64'(ren), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    step();

    // Zero-config starts and start under reset are ignored
    row_len_in = RAW'(0); num_channels_in = CHW'(2); Start = 1'b1;
    step(); Start = 1'b0; step();
    chk("start_rl0_ignored", 64'(busy), 64'(0));
    row_len_in = RAW'(3); num_channels_in = CHW'(0); Start = 1'b1;
    step(); Start = 1'b0; step();
    chk("start_ch0_ignored", 64'(busy), 64'(0));
    row_len_in = RAW'(3); num_channels_in = CHW'(1); Start = 1'b1; rst = 1'b1;
    step(); Start = 1'b0; rst = 1'b0; step();
    chk("rst_beats_start", 64'(busy), 64'(0));

    wq = {5, 6, 7}; l16 = {5, 6, 7}; l10 = {5, 6, 7};
    run_job(3, 1, wq, l16, l10, 0, 0, 0, 0);

    wq = {1, 2, 10, 20, 100, 200}; l16 = {111, 222}; l10 = {111, 222};
    run_job(2, 3, wq, l16, l10, 0, 0, 0, 0);

    wq = {40, 50, 60}; l16 = {40, 50, 60}; l10 = {40, 50, 60};
    run_job(3, 1, wq, l16, l10, 2, 0, 0, 0);

    wq = {1, 2, 3, 4, 10, 20, 30, 40}; l16 = {11, 22, 33, 44}; l10 = {11, 22, 33, 44};
    run_job(4, 2, wq, l16, l10, 0, 1, 3, 0);

`ifdef PSUM_ACC_SAT_EN
    wq = {1000, 1000}; l16 = {2000}; l10 = {1023};
`else
    wq = {1000, 1000}; l16 = {2000}; l10 = {976};
`endif
    run_job(1, 2, wq, l16, l10, 0, 0, 0, 0);

    // Row length above depth is clamped to 11 slots
    wq = {}; for (int i = 0; i < 11; i++) wq.push_back(32'(i * 3 + 1));
    l16 = {}; l10 = {};
    run_job(13, 1, wq, l16, l10, 1, 0, 0, 0);

    // Abort mid-pass, then a fresh one-word job must see no stale data
    for (int i = 0; i < 8; i++) fifo.push_back(DW'(i + 50));
    row_len_in = RAW'(4); num_channels_in = CHW'(2); Start = 1'b1;
    step(); Start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    fifo.delete();
    exp_q.delete();
    rst = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_out_valid", 64'(ov), 64'(0));
    chk("abort_out_data", 64'(od), 64'(0));
    wq = {9}; l16 = {9}; l10 = {9};
    run_job(1, 1, wq, l16, l10, 0, 0, 0, 0);

    for (int j = 0; j < 14; j++) begin
      int rl  = $urandom_range(1, 14);
      int nch = $urandom_range(1, 5);
      int eff = (rl > int'(DEPTH)) ? int'(DEPTH) : rl;
      wq = {}; l16 = {}; l10 = {};
      for (int i = 0; i < eff * nch; i++) wq.push_back($urandom_range(0, 1023));
      run_job(rl, nch, wq, l16, l10, $urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? 2 : 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, width of incoming Psum words.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, width of accumulator entries and output.
REQ-003 SHALL have parameter ROW_ADDR_WIDTH, default 4, index width of the row accumulator memory.
REQ-004 SHALL have parameter ROW_DEPTH, default 11, number of accumulator entries.
REQ-005 SHALL have parameter CH_WIDTH, default 4, width of the channel-count input.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port Start, input, 1, one-cycle pulse that latches configuration and begins a job.
REQ-009 SHALL have port row_len_in, input, ROW_ADDR_WIDTH, Psum words per pass.
REQ-010 SHALL have port num_channels_in, input, CH_WIDTH, number of passes to accumulate.
REQ-011 SHALL have port Psum, input, DATA_WIDTH, unsigned head word of the Psum FIFO.
REQ-012 SHALL have port valid_Psum, input, 1, Psum FIFO not empty.
REQ-013 SHALL have port ren_buf_Psum, output, 1, pops the Psum FIFO this cycle.
REQ-014 SHALL have port out_data, output, ACC_WIDTH, final accumulated sum.
REQ-015 SHALL have port out_valid, output, 1, out_data is valid.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-017 SHALL have port busy, output, 1, high in ACCUM.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when the job completes.

Function
REQ-019 SHALL implement states IDLE, ACCUM, DONE; DONE lasts one cycle and returns to IDLE.
REQ-020 SHALL, in IDLE on Start with row_len_in!=0 and num_channels_in!=0, latch both values (row_len clamped to ROW_DEPTH), clear idx and pass counters, enter ACCUM.
REQ-021 SHALL ignore Start when either config value is 0, and ignore Start outside IDLE.
REQ-022 SHALL consume a Psum word only in a cycle with ren_buf_Psum=1 and valid_Psum=1; ren_buf_Psum is never high when valid_Psum=0 or outside ACCUM.
REQ-023 SHALL, on pass 0, write zero-extended Psum to acc[idx]; on intermediate passes write acc[idx]+Psum.
REQ-024 SHALL, on the last pass, not write acc but load acc[idx]+Psum (pass 0 if single channel: Psum alone) into the output register, raising out_valid the next cycle (latency 1).
REQ-025 SHALL hold out_valid and out_data stable until out_ready=1; output register clears when out_valid&out_ready and no new load occurs.
REQ-026 SHALL, on the last pass, assert ren_buf_Psum only if output register is empty or drained this cycle (out_ready=1), allowing one word per cycle at full throughput.
REQ-027 SHALL increment idx per consumed word; at idx=row_len-1 wrap idx to 0 and increment pass.
REQ-028 SHALL enter DONE after the last word of the last pass has been consumed and its output accepted; done pulses during DONE.
REQ-029 SHALL perform additions at ACC_WIDTH with modulo-2^ACC_WIDTH wrap unless REQ-035 applies.

Reset
REQ-030 SHALL on rst set state IDLE, idx=0, pass=0, out_valid=0, out_data=0, ren_buf_Psum=0, busy=0, done=0.
REQ-031 SHALL on rst mid-job abort without consuming further Psum words; acc contents need not be cleared (pass 0 overwrites).
REQ-032 SHALL give rst priority over Start in the same cycle.

Configuration
REQ-033 SHALL support macro PSUM_ACC_SAT_EN.
REQ-034 SHALL, without PSUM_ACC_SAT_EN, wrap additions modulo 2^ACC_WIDTH.
REQ-035 SHALL, with PSUM_ACC_SAT_EN, clamp every sum (acc write and output) to 2^ACC_WIDTH-1 on overflow.

Verification
REQ-036 SHALL test row_len=3, channels=1, Psum 5,6,7 -> out_data 5,6,7, done after 3rd accept.
REQ-037 SHALL test row_len=2, channels=3, Psum 1,2,10,20,100,200 -> out_data 111,222.
REQ-038 SHALL test out_ready=0 for 4 cycles on first output -> out_data held, ren_buf_Psum=0 while full, no word lost.
REQ-039 SHALL test valid_Psum gaps (FIFO empty 5 cycles mid-pass) -> no spurious pop, results unchanged.
REQ-040 SHALL test ACC_WIDTH=10, channels=2, Psum 1000 twice -> 976 without macro, 1023 with PSUM_ACC_SAT_EN.
REQ-041 SHALL test rst mid-pass then Start row_len=1, channels=1, Psum 9 -> out_data 9, no stale data.
